// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic controller family: per-road light codes and
// the controller phase enum, plus the phase-to-light mapping used by decoders.
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'd0,
        LIGHT_YELLOW = 2'd1,
        LIGHT_GREEN  = 2'd2
    } light_t;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_t;

    // Colour shown by the road holding the phase; the spare encoding falls to RED.
    function automatic light_t phase_light(input phase_t ph);
        light_t l;
        case (ph)
            PH_GREEN:  l = LIGHT_GREEN;
            PH_YELLOW: l = LIGHT_YELLOW;
            default:   l = LIGHT_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/rr_next_select.sv
// Round-robin picker: first requesting road after cur (wrapping), never cur itself.
// Returns cur when nobody else is requesting.
module rr_next_select
    import traffic_pkg::*;
#(
    parameter int N_ROADS = 4
) (
    input  logic [N_ROADS-1:0]         req,
    input  logic [$clog2(N_ROADS)-1:0] cur,
    output logic [$clog2(N_ROADS)-1:0] nxt_road
);

    localparam int RW = $clog2(N_ROADS);

    logic [RW-1:0] idx_s;
    logic          found_s;

    // Walk offsets 1..N-1 from cur; the nearest requester wins.
    always_comb begin
        nxt_road = cur;
        found_s  = 1'b0;
        idx_s    = cur;
        for (int i = 1; i < N_ROADS; i++) begin
            idx_s = RW'((int'(cur) + i) % N_ROADS);
            if (!found_s && req[idx_s]) begin
                nxt_road = idx_s;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Intersection controller sharing one green phase among N_ROADS approaches,
// with min/max green, yellow, all-red clearance and emergency preemption.
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int N_ROADS   = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int CNT_W     = 4
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic [N_ROADS-1:0]           req,
    input  logic                         emer_valid,
    input  logic [$clog2(N_ROADS)-1:0]   emer_road,
    output logic [2*N_ROADS-1:0]         lights,
    output logic [$clog2(N_ROADS)-1:0]   cur_road,
    output logic [1:0]                   phase
);

    localparam int RW = $clog2(N_ROADS);

    localparam logic [CNT_W-1:0]     TIMER_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     TIMER_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     GMIN_LAST  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0]     GMAX_LAST  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0]     YEL_LAST   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0]     ARED_LAST  = CNT_W'(ALLRED_T - 1);
    localparam logic [RW-1:0]        ROAD_ZERO  = {RW{1'b0}};
    localparam logic [2*N_ROADS-1:0] LIGHTS_RST = {{(2*N_ROADS-2){1'b0}}, 2'd2};

    phase_t               phase_r, phase_s;
    logic [RW-1:0]        cur_r, cur_s;
    logic [RW-1:0]        nxt_r, nxt_s;
    logic [RW-1:0]        pick_s;
    logic [CNT_W-1:0]     timer_r, timer_s, timer_inc_s;
    logic [2*N_ROADS-1:0] lights_r, lights_s;
    logic [N_ROADS-1:0]   cur_mask_s, other_s;
    logic                 emer_s, emer_other_s, gap_out_s, max_out_s;

    rr_next_select #(.N_ROADS(N_ROADS)) u_rr (
        .req      (req),
        .cur      (cur_r),
        .nxt_road (pick_s)
    );

    // Demand seen from the green road: competing requests, exit conditions, legal preemption.
    always_comb begin
        cur_mask_s   = {{(N_ROADS-1){1'b0}}, 1'b1} << cur_r;
        other_s      = req & ~cur_mask_s;
        emer_s       = emer_valid && (int'(emer_road) < N_ROADS);
        emer_other_s = emer_s && (emer_road != cur_r);
        gap_out_s    = (timer_r >= GMIN_LAST) && !req[cur_r] && (other_s != {N_ROADS{1'b0}});
        max_out_s    = (timer_r == GMAX_LAST) && (other_s != {N_ROADS{1'b0}});
        timer_inc_s  = (timer_r == GMAX_LAST) ? timer_r : timer_r + TIMER_ONE;
    end

    // Phase sequencing; emergency overrides every green timing rule.
    always_comb begin
        phase_s = phase_r;
        cur_s   = cur_r;
        nxt_s   = nxt_r;
        timer_s = timer_r;
        case (phase_r)
            PH_GREEN: begin
                if (emer_other_s) begin
                    phase_s = PH_YELLOW;
                    nxt_s   = emer_road;
                    timer_s = TIMER_ZERO;
                end else if (emer_s) begin
                    timer_s = timer_inc_s;
                end else if (gap_out_s || max_out_s) begin
                    phase_s = PH_YELLOW;
                    nxt_s   = pick_s;
                    timer_s = TIMER_ZERO;
                end else begin
                    timer_s = timer_inc_s;
                end
            end
            PH_YELLOW: begin
                if (emer_s) begin
                    nxt_s = emer_road;
                end else begin
                    nxt_s = nxt_r;
                end
                if (timer_r == YEL_LAST) begin
                    phase_s = PH_ALLRED;
                    timer_s = TIMER_ZERO;
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            PH_ALLRED: begin
                if (emer_s) begin
                    nxt_s = emer_road;
                end else begin
                    nxt_s = nxt_r;
                end
                // A preemption arriving in the last all-red cycle still steers the new green.
                if (timer_r == ARED_LAST) begin
                    phase_s = PH_GREEN;
                    cur_s   = nxt_s;
                    timer_s = TIMER_ZERO;
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            default: begin
                phase_s = PH_GREEN;
                cur_s   = ROAD_ZERO;
                nxt_s   = ROAD_ZERO;
                timer_s = TIMER_ZERO;
            end
        endcase
    end

    // Light decode of the next state so the registered lights track the phase exactly.
    always_comb begin
        lights_s = {(2*N_ROADS){1'b0}};
        for (int k = 0; k < N_ROADS; k++) begin
            if (RW'(k) == cur_s) begin
                lights_s[2*k +: 2] = phase_light(phase_s);
            end else begin
                lights_s[2*k +: 2] = LIGHT_RED;
            end
        end
    end

    // State and output registers; clear forces road 0 green from any phase.
    always_ff @(posedge clk) begin
        if (clear) begin
            phase_r  <= PH_GREEN;
            cur_r    <= ROAD_ZERO;
            nxt_r    <= ROAD_ZERO;
            timer_r  <= TIMER_ZERO;
            lights_r <= LIGHTS_RST;
        end else begin
            phase_r  <= phase_s;
            cur_r    <= cur_s;
            nxt_r    <= nxt_s;
            timer_r  <= timer_s;
            lights_r <= lights_s;
        end
    end

    assign lights   = lights_r;
    assign cur_road = cur_r;
    assign phase    = phase_r;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Self-checking bench: directed timeline scenarios plus randomized traffic
// compared against a cycle-age reference model of the phase rules.
module tb_traffic_phase_arbiter;

    localparam int N_ROADS   = 4;
    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 12;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 2;

    logic       clk;
    logic       clear;
    logic [3:0] req;
    logic       emer_valid;
    logic [1:0] emer_road;
    logic [7:0] lights;
    logic [1:0] cur_road;
    logic [1:0] phase;

    int total;
    int bad;

    // Reference model: phase 0/1/2, road holding it, pending road, cycles spent in phase.
    int m_ph;
    int m_cur;
    int m_nxt;
    int m_age;

    traffic_phase_arbiter dut (
        .clk        (clk),
        .clear      (clear),
        .req        (req),
        .emer_valid (emer_valid),
        .emer_road  (emer_road),
        .lights     (lights),
        .cur_road   (cur_road),
        .phase      (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit rq(input int i);
        return ((req >> i) & 4'b0001) != 4'b0000;
    endfunction

    function automatic logic [7:0] m_lights();
        logic [7:0] v;
        v = 8'h00;
        if (m_ph == 0) v[2*m_cur +: 2] = 2'd2;
        else if (m_ph == 1) v[2*m_cur +: 2] = 2'd1;
        return v;
    endfunction

    // Advance the model with the inputs present at this edge, then the clock.
    task automatic tick();
        bit ev;
        int other;
        ev = (emer_valid === 1'b1);
        if (clear) begin
            m_ph = 0; m_cur = 0; m_nxt = 0; m_age = 0;
        end else if (m_ph == 0) begin
            other = 0;
            for (int k = 0; k < N_ROADS; k++) if (k != m_cur && rq(k)) other++;
            if (ev && int'(emer_road) != m_cur) begin
                m_ph = 1; m_nxt = int'(emer_road); m_age = 0;
            end else if (!ev && other > 0 &&
                         ((m_age >= GREEN_MIN - 1 && !rq(m_cur)) || m_age >= GREEN_MAX - 1)) begin
                for (int off = N_ROADS - 1; off >= 1; off--)
                    if (rq((m_cur + off) % N_ROADS)) m_nxt = (m_cur + off) % N_ROADS;
                m_ph = 1; m_age = 0;
            end else begin
                m_age++;
            end
        end else begin
            if (ev) m_nxt = int'(emer_road);
            if (m_age == ((m_ph == 1) ? YELLOW_T : ALLRED_T) - 1) begin
                if (m_ph == 2) m_cur = m_nxt;
                m_ph = (m_ph == 1) ? 2 : 0;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b0000; emer_valid = 1'b0; emer_road = 2'd0;
        do_clear();
        for (int c = 0; c < 50; c++) begin
            total++;
            if (lights !== 8'b00000010 || cur_road !== 2'd0 || phase !== 2'd0) begin
                bad++;
                $display("FAIL reset_idle c=%0d got lights=%b cur=%0d phase=%0d want 00000010/0/0",
                         c, lights, cur_road, phase);
            end
            tick();
        end
    endtask

    task automatic test_gapout();
        logic [1:0] eph;
        logic [1:0] ecur;
        logic [7:0] el;
        do_clear();
        req = 4'b0010;
        for (int c = 0; c <= 12; c++) begin
            if (c < 4)      begin eph = 2'd0; ecur = 2'd0; el = 8'b00000010; end
            else if (c < 7) begin eph = 2'd1; ecur = 2'd0; el = 8'b00000001; end
            else if (c < 9) begin eph = 2'd2; ecur = 2'd0; el = 8'b00000000; end
            else            begin eph = 2'd0; ecur = 2'd1; el = 8'b00001000; end
            total++;
            if (phase !== eph || cur_road !== ecur || lights !== el) begin
                bad++;
                $display("FAIL gapout c=%0d got %0d/%0d/%b want %0d/%0d/%b",
                         c, phase, cur_road, lights, eph, ecur, el);
            end
            tick();
        end
    endtask

    task automatic test_maxout();
        logic [1:0] eph;
        logic [1:0] ecur;
        do_clear();
        req = 4'b0011;
        for (int c = 0; c <= 35; c++) begin
            if (c < 12)      begin eph = 2'd0; ecur = 2'd0; end
            else if (c < 15) begin eph = 2'd1; ecur = 2'd0; end
            else if (c < 17) begin eph = 2'd2; ecur = 2'd0; end
            else if (c < 29) begin eph = 2'd0; ecur = 2'd1; end
            else if (c < 32) begin eph = 2'd1; ecur = 2'd1; end
            else if (c < 34) begin eph = 2'd2; ecur = 2'd1; end
            else             begin eph = 2'd0; ecur = 2'd0; end
            total++;
            if (phase !== eph || cur_road !== ecur) begin
                bad++;
                $display("FAIL maxout c=%0d got phase=%0d cur=%0d want %0d/%0d",
                         c, phase, cur_road, eph, ecur);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        do_clear();
        req = 4'b0010;
        repeat (9) tick();
        total++;
        if (cur_road !== 2'd1 || phase !== 2'd0) begin
            bad++; $display("FAIL rr_start got cur=%0d phase=%0d want 1/0", cur_road, phase);
        end
        req = 4'b1001;
        repeat (8) tick();
        total++;
        if (phase !== 2'd2 || cur_road !== 2'd1) begin
            bad++; $display("FAIL rr_allred got phase=%0d cur=%0d want 2/1", phase, cur_road);
        end
        tick();
        total++;
        if (cur_road !== 2'd3 || phase !== 2'd0 || lights !== 8'b10000000) begin
            bad++; $display("FAIL rr_to3 got cur=%0d phase=%0d lights=%b want 3/0/10000000",
                            cur_road, phase, lights);
        end
        req = 4'b0001;
        repeat (8) tick();
        total++;
        if (phase !== 2'd2 || cur_road !== 2'd3) begin
            bad++; $display("FAIL rr_allred2 got phase=%0d cur=%0d want 2/3", phase, cur_road);
        end
        tick();
        total++;
        if (cur_road !== 2'd0 || phase !== 2'd0) begin
            bad++; $display("FAIL rr_wrap got cur=%0d phase=%0d want 0/0", cur_road, phase);
        end
    endtask

    task automatic test_emergency();
        do_clear();
        req = 4'b0010;
        repeat (10) tick();
        total++;
        if (cur_road !== 2'd1 || phase !== 2'd0) begin
            bad++; $display("FAIL emer_start got cur=%0d phase=%0d want 1/0", cur_road, phase);
        end
        emer_valid = 1'b1; emer_road = 2'd2; req = 4'b1011;
        tick();
        total++;
        if (phase !== 2'd1 || cur_road !== 2'd1) begin
            bad++; $display("FAIL emer_yellow got phase=%0d cur=%0d want 1/1", phase, cur_road);
        end
        repeat (5) tick();
        total++;
        if (phase !== 2'd0 || cur_road !== 2'd2 || lights !== 8'b00100000) begin
            bad++; $display("FAIL emer_green got %0d/%0d/%b want 0/2/00100000",
                            phase, cur_road, lights);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if (phase !== 2'd0 || cur_road !== 2'd2) begin
                bad++; $display("FAIL emer_hold c=%0d got phase=%0d cur=%0d want 0/2",
                                c, phase, cur_road);
            end
        end
        emer_valid = 1'b0;
        tick();
        total++;
        if (phase !== 2'd1 || cur_road !== 2'd2) begin
            bad++; $display("FAIL emer_release got phase=%0d cur=%0d want 1/2", phase, cur_road);
        end
        repeat (5) tick();
        total++;
        if (phase !== 2'd0 || cur_road !== 2'd3) begin
            bad++; $display("FAIL emer_after got phase=%0d cur=%0d want 0/3", phase, cur_road);
        end
    endtask

    task automatic test_clear_mid();
        do_clear();
        req = 4'b0010;
        repeat (5) tick();
        total++;
        if (phase !== 2'd1) begin
            bad++; $display("FAIL clr_pre_yellow got phase=%0d want 1", phase);
        end
        do_clear();
        total++;
        if (lights !== 8'b00000010 || cur_road !== 2'd0 || phase !== 2'd0) begin
            bad++; $display("FAIL clr_yellow got %b/%0d/%0d want 00000010/0/0",
                            lights, cur_road, phase);
        end
        repeat (3) tick();
        total++;
        if (phase !== 2'd0) begin
            bad++; $display("FAIL clr_timer_green got phase=%0d want 0", phase);
        end
        tick();
        total++;
        if (phase !== 2'd1) begin
            bad++; $display("FAIL clr_timer_yellow got phase=%0d want 1", phase);
        end
        repeat (3) tick();
        total++;
        if (phase !== 2'd2) begin
            bad++; $display("FAIL clr_pre_allred got phase=%0d want 2", phase);
        end
        do_clear();
        total++;
        if (lights !== 8'b00000010 || cur_road !== 2'd0 || phase !== 2'd0) begin
            bad++; $display("FAIL clr_allred got %b/%0d/%0d want 00000010/0/0",
                            lights, cur_road, phase);
        end
        repeat (4) tick();
        total++;
        if (phase !== 2'd1 || cur_road !== 2'd0) begin
            bad++; $display("FAIL clr_allred_timer got phase=%0d cur=%0d want 1/0", phase, cur_road);
        end
    endtask

    task automatic test_random();
        int nonred;
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if (emer_valid) begin
                if ($urandom_range(0, 9) == 0) emer_valid = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                emer_valid = 1'b1;
                emer_road  = 2'($urandom_range(0, 3));
            end
            clear = ($urandom_range(0, 249) == 0);
            tick();
            total++;
            if (lights !== m_lights() || cur_road !== 2'(m_cur) || phase !== 2'(m_ph)) begin
                bad++;
                $display("FAIL random c=%0d got %b/%0d/%0d want %b/%0d/%0d",
                         c, lights, cur_road, phase, m_lights(), m_cur, m_ph);
            end
            nonred = 0;
            for (int k = 0; k < N_ROADS; k++) if (lights[2*k +: 2] != 2'd0) nonred++;
            total++;
            if (nonred > 1) begin
                bad++; $display("FAIL one_nonred c=%0d got %0d non-red roads want <=1", c, nonred);
            end
        end
        clear = 1'b0;
        emer_valid = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        m_ph = 0; m_cur = 0; m_nxt = 0; m_age = 0;
        clear = 1'b0; req = 4'b0000; emer_valid = 1'b0; emer_road = 2'd0;
        test_reset();
        test_gapout();
        test_maxout();
        test_round_robin();
        test_emergency();
        test_clear_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_arbiter.md
# traffic_phase_arbiter

Multi-approach intersection controller that shares one green phase among `N_ROADS` approaches using vehicle-sensor requests. It enforces minimum and maximum green, a yellow interval and an all-red clearance, and supports a single emergency-vehicle preemption input. It generalises the two-road highway/country controller and drives the per-road 2-bit light encodings used across the traffic designs.

## Interface
Parameters:
- `N_ROADS`, 4: number of approaches; 2..8.
- `GREEN_MIN`, 4: minimum green cycles; ≥1.
- `GREEN_MAX`, 12: maximum green cycles while any other road requests; > `GREEN_MIN`.
- `YELLOW_T`, 3: yellow cycles; ≥1.
- `ALLRED_T`, 2: all-red cycles; ≥1.
- `CNT_W`, 4: timer width; must hold `GREEN_MAX`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `clear`, input, 1: reset, synchronous, active-high.
- `req`, input, `N_ROADS`: level vehicle-present sensor, one bit per road.
- `emer_valid`, input, 1: emergency preemption active.
- `emer_road`, input, `$clog2(N_ROADS)`: road demanded by the emergency vehicle.
- `lights`, output, `2*N_ROADS`: road k occupies bits [2k+1:2k]; RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
- `cur_road`, output, `$clog2(N_ROADS)`: road holding the phase.
- `phase`, output, 2: GREEN=0, YELLOW=1, ALLRED=2.

## Operation
- States: GREEN, YELLOW, ALLRED. Registers: `cur`, `nxt`, `timer`.
- Reset (`clear`=1 at an edge): phase=GREEN, cur=0, timer=0, nxt=0. `lights` = road 0 GREEN, all other roads RED. Reset wins over every other input, including mid-yellow or mid-all-red.
- `lights` decode: road `cur` shows GREEN in GREEN and YELLOW in YELLOW. Every other road is RED. All roads are RED in ALLRED.
- GREEN:
  - `timer` increments each cycle and saturates at `GREEN_MAX`-1.
  - `other` = req with the bit for `cur` masked off.
  - Gap-out: when `timer`≥`GREEN_MIN`-1, `req[cur]`=0 and `other`≠0, go to YELLOW.
  - Max-out: when `timer`=`GREEN_MAX`-1 and `other`≠0, go to YELLOW, regardless of `req[cur]`.
  - If `other`=0, rest on green indefinitely.
- Next-road choice, latched into `nxt` on the GREEN→YELLOW transition: the first road with `req`=1 scanning cur+1, cur+2, … modulo `N_ROADS`, excluding `cur`.
- YELLOW: lasts `YELLOW_T` cycles, then ALLRED.
- ALLRED: lasts `ALLRED_T` cycles, then GREEN with cur←nxt and timer←0.
- Requests dropped during YELLOW/ALLRED do not cancel the switch.
- Emergency (priority over all timer rules):
  - In GREEN with `cur`≠`emer_road`: go to YELLOW at the next edge, ignoring `GREEN_MIN`; nxt←`emer_road`.
  - In GREEN with `cur`=`emer_road`: hold GREEN. Gap-out and max-out are suppressed while `emer_valid`=1.
  - In YELLOW/ALLRED: nxt←`emer_road` every cycle `emer_valid`=1. The interval lengths are unchanged.
- Only GREEN or RED may follow YELLOW for a road. There is never more than one non-RED road.

## Timing
- All outputs are registered and reflect the current state. No combinational path from inputs to outputs.
- Decision latency: the exit condition is sampled at edge t, and `phase`=YELLOW is visible from t+1.
- Minimum green is exactly `GREEN_MIN` cycles. Yellow is exactly `YELLOW_T`. All-red is exactly `ALLRED_T`.
- Green-to-green switch cost is `YELLOW_T`+`ALLRED_T` cycles (5 with defaults).
- `timer` reloads to 0 on every phase entry and counts phase cycles.

## Structure
- Package `traffic_pkg`: light encodings RED/YELLOW/GREEN, phase enum (GREEN/YELLOW/ALLRED), shared by all traffic blocks.
- Sub-module `rr_next_select`: combinational round-robin picker with inputs `req`, `cur` and output `nxt_road`, parameterised by `N_ROADS`.
- Top level holds the FSM, timer and light decode.

## Test plan
- Reset, then `req`=0 for 50 cycles → `lights`=8'b00000010, `cur_road`=0, `phase`=GREEN throughout.
- `req`=4'b0010 from release → road 0 GREEN cycles 0–3, YELLOW 4–6, ALLRED 7–8, road 1 GREEN from cycle 9.
- `req`=4'b0011 held → road 0 GREEN for exactly 12 cycles (max-out), then road 1. From road 1 (`req[1]` still 1), road 0 gets green after 12+5 cycles.
- Round-robin: cur=1, `req`=4'b1001 at gap-out → nxt=3. Next switch with `req`=4'b0001 → road 0.
- Emergency: road 1 GREEN at timer=1, `emer_valid`=1 with `emer_road`=2 → YELLOW next cycle, road 2 GREEN 5 cycles later. It holds green past 12 cycles while `emer_valid`=1, even with other requests.
- `clear` asserted mid-YELLOW and mid-ALLRED → next cycle road 0 GREEN, timer=0, no other road non-RED.
